pixel_fetch: RTL and testbench
==============================

# pixel_fetch

Parametrised pixel fetch and colour-expansion stage between the VGA timing generator and the image ROM. It takes a linear pixel address and a per-pixel bits-per-pixel mode (1/2/4/8 bpp) and issues the ROM word read. It then extracts the pixel field MSB-first and maps it to RGB, either through a writable 16-entry palette or by direct RGB332 expansion. It supersedes the fixed 1 bpp black/white fetch, and its reset-default palette reproduces the old 1 bpp output exactly.

## Interface
- ADDR_W, 19, pixel address width; also the width of rom_addr, which is zero-extended.
- WORD_W, 8, ROM word width; must be a power of two and at least 8.
- COLOR_W, 8, width of each output colour channel.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  the pixel address is valid this cycle; low means blanking.
- vga_addr  in  ADDR_W  linear pixel index.
- bpp_sel  in  2  mode: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp RGB332; sampled per pixel with vga_addr.
- rom_rden  out  1  combinational, equal to in_valid.
- rom_addr  out  ADDR_W  combinational word address; the ROM has a 1-cycle registered read.
- rom_data  in  WORD_W  ROM read data, valid one cycle after rom_addr.
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry to write.
- pal_data  in  3*COLOR_W  write data as {R,G,B}, with R in the MSBs.
- out_valid  out  1  the RGB outputs carry a pixel.
- o_red, o_green, o_blue  out  COLOR_W each  pixel colour.

## Operation
- Field width: b = 1, 2, 4 or 8 bits per pixel. Pixels per word: ppw = WORD_W/b.
- Word address: rom_addr = vga_addr >> log2(ppw). Offset: k = vga_addr mod ppw.
- Field extraction: the field is rom_data[WORD_W-1-k*b -: b], so pixel 0 is in the MSBs.
- Index formation, modes 0–2: the field is bit-replicated to 4 bits to form the palette index.
  - 1 bpp: 0→0x0, 1→0xF.
  - 2 bpp: ab→abab.
  - 4 bpp: the field is used directly.
- Colour output, modes 0–2: RGB is the palette entry at that index.
- Mode 3: the 8-bit field is expanded as R=f[7:5], G=f[4:2], B=f[1:0]. Each channel is bit-replicated MSB-first to COLOR_W, so 3'b111→all ones and 2'b01→0x55 at COLOR_W=8. The palette is bypassed.
- Palette storage: 16 × 3·COLOR_W registers, written on the edge where pal_we=1.
- Reset default palette: each channel of entry i is i[3:0] replicated to fill COLOR_W, MSB-aligned and truncated. Entry 0 is 0x00 and entry 15 is 0xFF.
- Blanking: if a pipeline slot has valid=0, the outputs register 0 on all channels and out_valid=0.
- Mode changes between consecutive pixels are glitch-free, because bpp_sel travels down the pipeline with its pixel.

## Timing
- Pipeline: 3 stages, fully pipelined, one pixel per cycle, no back-pressure.
- Cycle n: vga_addr, bpp_sel and in_valid are presented; rom_addr and rom_rden are driven combinationally.
  - Edge ending cycle n: the ROM latches the address; s1 captures {valid, k, mode}.
- Cycle n+1: rom_data is valid.
  - Edge: s2 captures {valid, mode, 8-bit field, zero-extended}.
- Cycle n+2: combinational palette read or RGB332 expansion.
  - Edge: o_red/o_green/o_blue and out_valid are registered.
- Cycle n+3: outputs are valid. Latency is exactly 3 cycles.
- Palette write/read collision: a write on the same edge that captures an output returns the old entry. Pixels reaching that edge later see the new value.
- Reset values: out_valid=0 and o_red=o_green=o_blue=0. All stage valids are 0 and all stage data registers are 0. The palette holds its defaults.
- Reset mid-stream: in-flight pixels are discarded. out_valid stays 0 until 3 cycles after the first valid pixel presented after rst deasserts.
- pal_we during rst is ignored; reset wins.

## Structure
- Package pixel_fetch_pkg holds:
  - mode constants BPP_1, BPP_2, BPP_4 and BPP_8_RGB332;
  - PAL_DEPTH=16 and PAL_IDX_W=4;
  - function default_pal_entry(i, COLOR_W);
  - function rep_expand(value, src_w, COLOR_W) for bit-replication.
- Sub-module pixel_palette: the 16-entry register file with synchronous write, synchronous reset to defaults and a combinational read port.
- Field extraction and the pipeline stay in pixel_fetch.

## Test plan
- 1 bpp: reset, then pixels 0–7 on consecutive cycles, with rom_data=0xA5 for word 0.
  - Required: rom_addr=0 throughout.
  - Required: from cycle 3, out_valid=1 and RGB = FF,00,FF,00,00,FF,00,FF (all channels equal).
- 2 bpp: vga_addr=5 with rom_data=0x1B.
  - Required: rom_addr=1, field 01, index 5, RGB 55/55/55 three cycles later.
- 4 bpp: write palette entry 3 with 0x123456, then present vga_addr=1 with rom_data=0xF3.
  - Required: rom_addr=0 and RGB 12/34/56.
- 8 bpp: vga_addr=0x40 with rom_data=0xE3.
  - Required: rom_addr=0x40 and RGB FF/00/FF.
- Collision and blanking: a write of 0xABCDEF to entry 5 lands on the same edge that captures an index-5 pixel; that pixel uses the old value and the next index-5 pixel yields AB/CD/EF. Separately, in_valid low for 2 cycles gives out_valid=0 and RGB=0 for exactly 2 cycles.
- Reset mid-stream: pulse rst for 1 cycle with 3 pixels in flight and the palette modified.
  - Required: out_valid=0 for the next 3 cycles.
  - Required: a following 1 bpp '1' pixel yields FF/FF/FF (defaults restored).

Source files
------------

// File: rtl/pixel_fetch_pkg.sv
// Mode constants, palette sizing and bit-replication helpers shared by the
// pixel fetch pipeline and its palette.
package pixel_fetch_pkg;
  localparam logic [1:0] BPP_1        = 2'd0;
  localparam logic [1:0] BPP_2        = 2'd1;
  localparam logic [1:0] BPP_4        = 2'd2;
  localparam logic [1:0] BPP_8_RGB332 = 2'd3;

  localparam int PAL_DEPTH   = 16;
  localparam int PAL_IDX_W   = 4;
  localparam int MAX_COLOR_W = 32;

  // Repeats the low src_w bits of value MSB-first, then keeps the top color_w bits.
  function automatic logic [MAX_COLOR_W-1:0] rep_expand(input logic [7:0] value,
                                                        input int src_w,
                                                        input int color_w);
    logic [63:0] acc;
    logic [63:0] src;
    int          total;
    acc   = '0;
    total = 0;
    src   = 64'(value) & ((64'd1 << src_w) - 64'd1);
    for (int r = 0; r < MAX_COLOR_W; r++) begin
      if (total < color_w) begin
        acc   = (acc << src_w) | src;
        total = total + src_w;
      end
    end
    return MAX_COLOR_W'(acc >> (total - color_w));
  endfunction

  // All three channels of a default entry share this value.
  function automatic logic [MAX_COLOR_W-1:0] default_pal_entry(input logic [PAL_IDX_W-1:0] i,
                                                               input int color_w);
    return rep_expand({4'b0000, i}, PAL_IDX_W, color_w);
  endfunction
endpackage

// File: rtl/pixel_palette.sv
// 16-entry {R,G,B} palette: synchronous write, reset to a grey ramp, combinational read.
module pixel_palette
  import pixel_fetch_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [PAL_IDX_W-1:0] waddr_i,
  input  logic [3*COLOR_W-1:0] wdata_i,
  input  logic [PAL_IDX_W-1:0] raddr_i,
  output logic [3*COLOR_W-1:0] rdata_o
);
  logic [3*COLOR_W-1:0] pal_q [PAL_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_q[i] <= {3{COLOR_W'(default_pal_entry(PAL_IDX_W'(i), COLOR_W))}};
      end
    end else if (we_i) begin
      pal_q[waddr_i] <= wdata_i;
    end
  end

  // Read before write: a same-edge write is seen only by later reads.
  assign rdata_o = pal_q[raddr_i];
endmodule

// File: rtl/pixel_fetch.sv
// Three-stage pixel fetch: ROM word addressing, MSB-first field extraction,
// then palette lookup or RGB332 expansion into registered RGB outputs.
module pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int WORD_W  = 8,
  parameter int COLOR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ADDR_W-1:0]    vga_addr,
  input  logic [1:0]           bpp_sel,
  output logic                 rom_rden,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [WORD_W-1:0]    rom_data,
  input  logic                 pal_we,
  input  logic [PAL_IDX_W-1:0] pal_addr,
  input  logic [3*COLOR_W-1:0] pal_data,
  output logic                 out_valid,
  output logic [COLOR_W-1:0]   o_red,
  output logic [COLOR_W-1:0]   o_green,
  output logic [COLOR_W-1:0]   o_blue
);
  localparam int               OFS_W    = $clog2(WORD_W);
  localparam logic [OFS_W-1:0] OFS_MASK = OFS_W'(WORD_W - 1);

  // Stage 0: word address and pixel offset; log2(ppw) = log2(WORD_W) - mode
  logic [OFS_W-1:0] k_d;

  always_comb begin
    rom_rden = in_valid;
    rom_addr = vga_addr >> (OFS_W - int'(bpp_sel));
    k_d      = vga_addr[OFS_W-1:0] & (OFS_MASK >> bpp_sel);
  end

  logic             vld_p1_q;
  logic [OFS_W-1:0] k_p1_q;
  logic [1:0]       mode_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      k_p1_q    <= '0;
      mode_p1_q <= BPP_1;
    end else begin
      vld_p1_q  <= in_valid;
      k_p1_q    <= k_d;
      mode_p1_q <= bpp_sel;
    end
  end

  // Stage 1: ROM word arrives; pixel k sits k fields below the MSB
  int                fw;
  logic [WORD_W-1:0] aligned;
  logic [7:0]        field_d;

  always_comb begin
    fw      = 1 << mode_p1_q;
    aligned = rom_data >> (WORD_W - (int'(k_p1_q) + 1) * fw);
    field_d = aligned[7:0] & (8'hFF >> (8 - fw));
  end

  logic       vld_p2_q;
  logic [1:0] mode_p2_q;
  logic [7:0] field_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      mode_p2_q  <= BPP_1;
      field_p2_q <= '0;
    end else begin
      vld_p2_q   <= vld_p1_q;
      mode_p2_q  <= mode_p1_q;
      field_p2_q <= field_d;
    end
  end

  // Stage 2: palette index by field replication, or direct RGB332 expansion
  logic [PAL_IDX_W-1:0] idx_d;
  logic [3*COLOR_W-1:0] pal_rgb;
  logic [COLOR_W-1:0]   red_d, green_d, blue_d;

  always_comb begin
    unique case (mode_p2_q)
      BPP_1:   idx_d = {4{field_p2_q[0]}};
      BPP_2:   idx_d = {2{field_p2_q[1:0]}};
      default: idx_d = field_p2_q[3:0];
    endcase
  end

  pixel_palette #(
    .COLOR_W (COLOR_W)
  ) u_palette (
    .clk     (clk),
    .rst     (rst),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_data),
    .raddr_i (idx_d),
    .rdata_o (pal_rgb)
  );

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (vld_p2_q) begin
      if (mode_p2_q == BPP_8_RGB332) begin
        red_d   = COLOR_W'(rep_expand({5'b0, field_p2_q[7:5]}, 3, COLOR_W));
        green_d = COLOR_W'(rep_expand({5'b0, field_p2_q[4:2]}, 3, COLOR_W));
        blue_d  = COLOR_W'(rep_expand({6'b0, field_p2_q[1:0]}, 2, COLOR_W));
      end else begin
        {red_d, green_d, blue_d} = pal_rgb;
      end
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o_red     <= '0;
      o_green   <= '0;
      o_blue    <= '0;
    end else begin
      out_valid <= vld_p2_q;
      o_red     <= red_d;
      o_green   <= green_d;
      o_blue    <= blue_d;
    end
  end
endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: directed scenarios plus randomized traffic
// against a per-pixel arithmetic model with a ROM and palette shadow.
module tb_pixel_fetch;
  localparam int ADDR_W  = 19;
  localparam int WORD_W  = 8;
  localparam int COLOR_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [ADDR_W-1:0]    vga_addr;
  logic [1:0]           bpp_sel;
  logic                 rom_rden;
  logic [ADDR_W-1:0]    rom_addr;
  logic [WORD_W-1:0]    rom_data;
  logic                 pal_we;
  logic [3:0]           pal_addr;
  logic [3*COLOR_W-1:0] pal_data;
  logic                 out_valid;
  logic [COLOR_W-1:0]   o_red, o_green, o_blue;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic       v;
    logic [1:0] m;
    logic [7:0] f;
  } pix_t;

  logic [7:0]  mem   [256];
  logic [23:0] pal_m [16];
  pix_t        hist1 = '0;
  pix_t        hist2 = '0;

  logic [ADDR_W-1:0] obs_ra, exp_ra;
  logic              obs_rden, obs_ov, exp_ov;
  logic [23:0]       obs_rgb, exp_rgb;

  pixel_fetch #(
    .ADDR_W  (ADDR_W),
    .WORD_W  (WORD_W),
    .COLOR_W (COLOR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .vga_addr  (vga_addr),
    .bpp_sel   (bpp_sel),
    .rom_rden  (rom_rden),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pal_we    (pal_we),
    .pal_addr  (pal_addr),
    .pal_data  (pal_data),
    .out_valid (out_valid),
    .o_red     (o_red),
    .o_green   (o_green),
    .o_blue    (o_blue)
  );

  always #5 clk = ~clk;

  // ROM with a one-cycle registered read
  always @(posedge clk) if (rom_rden) rom_data <= mem[rom_addr[7:0]];

  function automatic logic [23:0] model_rgb(input logic [1:0] m, input logic [7:0] f);
    int r3, g3, b2, idx;
    if (m == 2'd3) begin
      r3 = f / 32;
      g3 = (f / 4) % 8;
      b2 = f % 4;
      return {8'((r3 << 5) | (r3 << 2) | (r3 >> 1)),
              8'((g3 << 5) | (g3 << 2) | (g3 >> 1)),
              8'(b2 * 85)};
    end
    case (m)
      2'd0:    idx = (f != 0) ? 15 : 0;
      2'd1:    idx = f * 5;
      default: idx = f;
    endcase
    return pal_m[idx];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
    hist1 = '0;
    hist2 = '0;
  endtask

  // One clock: drive inputs, sample the combinational ROM port, then the registered outputs.
  task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [1:0] m,
                      input bit we = 1'b0, input logic [3:0] wa = '0,
                      input logic [23:0] wd = '0, input bit r = 1'b0);
    pix_t       cur;
    int         b, ppw, k;
    logic [7:0] word;
    rst = r; in_valid = v; vga_addr = a; bpp_sel = m;
    pal_we = we; pal_addr = wa; pal_data = wd;
    b      = 1 << m;
    ppw    = 8 / b;
    k      = int'(a) % ppw;
    exp_ra = a / ADDR_W'(ppw);
    word   = mem[exp_ra[7:0]];
    cur.v  = v;
    cur.m  = m;
    cur.f  = 8'((int'(word) >> (8 - (k + 1) * b)) % (1 << b));
    if (r || !hist2.v) begin
      exp_ov  = 1'b0;
      exp_rgb = '0;
    end else begin
      exp_ov  = 1'b1;
      exp_rgb = model_rgb(hist2.m, hist2.f);
    end
    #1;
    obs_ra   = rom_addr;
    obs_rden = rom_rden;
    @(posedge clk);
    #1;
    obs_ov  = out_valid;
    obs_rgb = {o_red, o_green, o_blue};
    if (r) begin
      reset_model();
    end else begin
      if (we) pal_m[wa] = wd;
      hist2 = hist1;
      hist1 = cur;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      step(1'b0, '0, 2'd0, 1'b0, '0, '0, 1'b1);
      tests_run++;
      if (obs_ov !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_valid: got %b want 0", obs_ov);
      end
      tests_run++;
      if (obs_rgb !== 24'h0) begin
        tests_failed++;
        $display("FAIL reset_rgb: got %h want 000000", obs_rgb);
      end
    end
  endtask

  task automatic test_1bpp();
    logic [7:0] tbl [8];
    tbl = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
    mem[0] = 8'hA5;
    for (int s = 0; s < 10; s++) begin
      step(s < 8, ADDR_W'(s < 8 ? s : 0), 2'd0);
      if (s < 8) begin
        tests_run++;
        if (obs_ra !== '0) begin
          tests_failed++;
          $display("FAIL 1bpp_addr px%0d: got %h want 0", s, obs_ra);
        end
      end
      tests_run++;
      if (obs_ov !== (s >= 2)) begin
        tests_failed++;
        $display("FAIL 1bpp_valid step%0d: got %b want %b", s, obs_ov, s >= 2);
      end
      if (s >= 2) begin
        tests_run++;
        if (obs_rgb !== {3{tbl[s-2]}}) begin
          tests_failed++;
          $display("FAIL 1bpp_rgb px%0d: got %h want %h", s - 2, obs_rgb, {3{tbl[s-2]}});
        end
      end
    end
  endtask

  task automatic test_2bpp();
    mem[1] = 8'h1B;
    step(1'b1, 19'd5, 2'd1);
    tests_run++;
    if (obs_ra !== 19'd1) begin
      tests_failed++;
      $display("FAIL 2bpp_addr: got %h want 1", obs_ra);
    end
    step(1'b0, '0, 2'd0);
    step(1'b0, '0, 2'd0);
    tests_run++;
    if (obs_ov !== 1'b1 || obs_rgb !== 24'h555555) begin
      tests_failed++;
      $display("FAIL 2bpp_rgb: got v=%b %h want v=1 555555", obs_ov, obs_rgb);
    end
  endtask

  task automatic test_4bpp();
    mem[0] = 8'hF3;
    step(1'b0, '0, 2'd0, 1'b1, 4'd3, 24'h123456);
    step(1'b1, 19'd1, 2'd2);
    tests_run++;
    if (obs_ra !== 19'd0) begin
      tests_failed++;
      $display("FAIL 4bpp_addr: got %h want 0", obs_ra);
    end
    step(1'b0, '0, 2'd0);
    step(1'b0, '0, 2'd0);
    tests_run++;
    if (obs_ov !== 1'b1 || obs_rgb !== 24'h123456) begin
      tests_failed++;
      $display("FAIL 4bpp_rgb: got v=%b %h want v=1 123456", obs_ov, obs_rgb);
    end
  endtask

  task automatic test_8bpp();
    mem[8'h40] = 8'hE3;
    step(1'b1, 19'h40, 2'd3);
    tests_run++;
    if (obs_ra !== 19'h40) begin
      tests_failed++;
      $display("FAIL 8bpp_addr: got %h want 40", obs_ra);
    end
    step(1'b0, '0, 2'd0);
    step(1'b0, '0, 2'd0);
    tests_run++;
    if (obs_ov !== 1'b1 || obs_rgb !== 24'hFF00FF) begin
      tests_failed++;
      $display("FAIL 8bpp_rgb: got v=%b %h want v=1 FF00FF", obs_ov, obs_rgb);
    end
  endtask

  task automatic test_collision();
    mem[2] = 8'h55;
    step(1'b1, 19'd4, 2'd2);
    step(1'b1, 19'd5, 2'd2);
    step(1'b0, '0, 2'd0, 1'b1, 4'd5, 24'hABCDEF);
    tests_run++;
    if (obs_rgb !== 24'h555555) begin
      tests_failed++;
      $display("FAIL collision_old: got %h want 555555", obs_rgb);
    end
    step(1'b0, '0, 2'd0);
    tests_run++;
    if (obs_rgb !== 24'hABCDEF) begin
      tests_failed++;
      $display("FAIL collision_new: got %h want ABCDEF", obs_rgb);
    end
  endtask

  task automatic test_blanking();
    logic [7:0] vpat;
    vpat = 8'b0011_0011;  // bit s = in_valid at step s
    for (int s = 0; s < 8; s++) begin
      step(vpat[s], ADDR_W'($urandom_range(0, 2047)), 2'd0);
      tests_run++;
      if (obs_ov !== exp_ov || obs_rgb !== exp_rgb) begin
        tests_failed++;
        $display("FAIL blank_model step%0d: got v=%b %h want v=%b %h", s, obs_ov, obs_rgb, exp_ov, exp_rgb);
      end
      tests_run++;
      if (obs_ov !== (s >= 2 && vpat[s-2])) begin
        tests_failed++;
        $display("FAIL blank_valid step%0d: got %b", s, obs_ov);
      end
      if (s == 4 || s == 5) begin
        tests_run++;
        if (obs_rgb !== 24'h0) begin
          tests_failed++;
          $display("FAIL blank_rgb step%0d: got %h want 000000", s, obs_rgb);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    mem[3] = 8'hFF;
    step(1'b0, '0, 2'd0, 1'b1, 4'd15, 24'h010203);
    step(1'b1, 19'd24, 2'd0);
    step(1'b1, 19'd25, 2'd0);
    step(1'b1, 19'd26, 2'd0);
    step(1'b0, '0, 2'd0, 1'b1, 4'd15, 24'h777777, 1'b1);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step(1'b0, '0, 2'd0);
      tests_run++;
      if (obs_ov !== 1'b0 || obs_rgb !== 24'h0) begin
        tests_failed++;
        $display("FAIL midrst_flush%0d: got v=%b %h want v=0 000000", s, obs_ov, obs_rgb);
      end
    end
    step(1'b1, 19'd24, 2'd0);
    step(1'b0, '0, 2'd0);
    tests_run++;
    if (obs_ov !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_early: got %b want 0", obs_ov);
    end
    step(1'b0, '0, 2'd0);
    tests_run++;
    if (obs_ov !== 1'b1 || obs_rgb !== 24'hFFFFFF) begin
      tests_failed++;
      $display("FAIL midrst_default: got v=%b %h want v=1 FFFFFF", obs_ov, obs_rgb);
    end
  endtask

  task automatic test_random();
    bit v, we, r;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int s = 0; s < 400; s++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 63) == 0);
      step(v, ADDR_W'($urandom), 2'($urandom), we, 4'($urandom), 24'($urandom), r);
      if (v) begin
        tests_run++;
        if (obs_ra !== exp_ra || obs_rden !== 1'b1) begin
          tests_failed++;
          $display("FAIL rand_addr step%0d: got %h/%b want %h/1", s, obs_ra, obs_rden, exp_ra);
        end
      end
      tests_run++;
      if (obs_ov !== exp_ov || obs_rgb !== exp_rgb) begin
        tests_failed++;
        $display("FAIL rand_pixel step%0d: got v=%b %h want v=%b %h", s, obs_ov, obs_rgb, exp_ov, exp_rgb);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset_model();
    test_reset();
    test_1bpp();
    test_2bpp();
    test_4bpp();
    test_8bpp();
    test_collision();
    test_blanking();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
